// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both
// sides, signed-overflow flag for add, and an n/z/p condition-code register
// that updates when a tagged result retires.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       op,
    input  logic [SHW-1:0]   shift,
    input  logic             ld_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             ovf,
    output logic             n,
    output logic             z,
    output logic             p
);

    // Result of one operation on already-registered operands.
    function automatic logic [WIDTH-1:0] alu_calc(
        input logic [2:0]       f_op,
        input logic [WIDTH-1:0] f_a,
        input logic [WIDTH-1:0] f_b,
        input logic [SHW-1:0]   f_sh
    );
        logic [WIDTH-1:0] r;
        case (f_op)
            3'b000:  r = f_a + f_b;
            3'b001:  r = f_a & f_b;
            3'b010:  r = ~f_a;
            3'b011:  r = f_a ^ f_b;
            3'b100:  r = f_a << f_sh;
            3'b101:  r = f_a >> f_sh;
            3'b110:  r = $signed(f_a) >>> f_sh;
            3'b111:  r = {WIDTH{1'b0}};
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    // Signed overflow: operands share a sign and the sum's sign differs.
    function automatic logic add_ovf(
        input logic [2:0]       f_op,
        input logic [WIDTH-1:0] f_a,
        input logic [WIDTH-1:0] f_b,
        input logic [WIDTH-1:0] f_r
    );
        logic v;
        if (f_op == 3'b000) begin
            v = (f_a[WIDTH-1] == f_b[WIDTH-1]) && (f_r[WIDTH-1] != f_a[WIDTH-1]);
        end else begin
            v = 1'b0;
        end
        return v;
    endfunction

    // Stage 1 registers
    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_in1_r;
    logic [WIDTH-1:0] s1_in2_r;
    logic [2:0]       s1_op_r;
    logic [SHW-1:0]   s1_shift_r;
    logic             s1_ld_cc_r;

    // Stage 2 registers (out/ovf/out_valid are driven straight from these)
    logic             s2_valid_r;
    logic [WIDTH-1:0] s2_out_r;
    logic             s2_ovf_r;
    logic             s2_ld_cc_r;

    // Condition-code register
    logic             n_r;
    logic             z_r;
    logic             p_r;

    logic             s2_load_s;
    logic             retire_s;
    logic             accept_s;
    logic [WIDTH-1:0] res_s;
    logic             res_ovf_s;

    // Handshake decode: S2 may load when empty or draining this cycle.
    always_comb begin
        retire_s  = s2_valid_r && out_ready;
        s2_load_s = !s2_valid_r || out_ready;
        in_ready  = !s1_valid_r || s2_load_s;
        accept_s  = in_valid && in_ready;
    end

    // Compute the stage-2 result from the stage-1 operands.
    always_comb begin
        res_s     = alu_calc(s1_op_r, s1_in1_r, s1_in2_r, s1_shift_r);
        res_ovf_s = add_ovf(s1_op_r, s1_in1_r, s1_in2_r, res_s);
    end

    // Stage 1: capture a request whenever the slot is free or moving on.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_in1_r   <= {WIDTH{1'b0}};
            s1_in2_r   <= {WIDTH{1'b0}};
            s1_op_r    <= 3'b000;
            s1_shift_r <= {SHW{1'b0}};
            s1_ld_cc_r <= 1'b0;
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (accept_s) begin
                s1_in1_r   <= in1;
                s1_in2_r   <= in2;
                s1_op_r    <= op;
                s1_shift_r <= shift;
                s1_ld_cc_r <= ld_cc;
            end
        end
    end

    // Stage 2: take the computed result; hold it while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_r <= 1'b0;
            s2_out_r   <= {WIDTH{1'b0}};
            s2_ovf_r   <= 1'b0;
            s2_ld_cc_r <= 1'b0;
        end else if (s2_load_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_out_r   <= res_s;
                s2_ovf_r   <= res_ovf_s;
                s2_ld_cc_r <= s1_ld_cc_r;
            end
        end
    end

    // Condition codes follow a retiring result that carries the ld_cc tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_r <= 1'b0;
            z_r <= 1'b1;
            p_r <= 1'b0;
        end else if (retire_s && s2_ld_cc_r) begin
            n_r <= s2_out_r[WIDTH-1];
            z_r <= (s2_out_r == {WIDTH{1'b0}});
            p_r <= !s2_out_r[WIDTH-1] && (s2_out_r != {WIDTH{1'b0}});
        end
    end

    assign out_valid = s2_valid_r;
    assign out       = s2_out_r;
    assign ovf       = s2_ovf_r;
    assign n         = n_r;
    assign z         = z_r;
    assign p         = p_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: randomized traffic against a queue-based
// reference model, plus directed cases and a 32-bit instance.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, ld_cc, out_valid, out_ready, ovf, n, z, p;
    logic [15:0] in1, in2, out;
    logic [2:0]  op;
    logic [3:0]  shift;

    logic        in_valid32, in_ready32, ld_cc32, out_valid32, out_ready32, ovf32, n32, z32, p32;
    logic [31:0] in1_32, in2_32, out32;
    logic [2:0]  op32;
    logic [4:0]  shift32;

    int n_cmp = 0;
    int n_err = 0;
    int edge_cnt = 0;

    typedef struct {
        longint res;
        bit     ov;
        bit     ld;
        int     cyc;
    } ent_t;

    ent_t     q[$];
    bit [2:0] cc_m;

    localparam longint M = 65536;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(16), .SHW(4)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .op(op), .shift(shift), .ld_cc(ld_cc),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .ovf(ovf),
        .n(n), .z(z), .p(p)
    );

    alu_pipe #(.WIDTH(32), .SHW(5)) u_dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32),
        .in1(in1_32), .in2(in2_32), .op(op32), .shift(shift32), .ld_cc(ld_cc32),
        .out_valid(out_valid32), .out_ready(out_ready32), .out(out32), .ovf(ovf32),
        .n(n32), .z(z32), .p(p32)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint sgn(input longint v);
        return (v >= 32768) ? v - M : v;
    endfunction

    // Reference result from plain integer arithmetic.
    function automatic longint ref_out(input int opc, input longint a, input longint b, input int s);
        longint d, sv, qv;
        d = longint'(1) << s;
        case (opc)
            0: return (a + b) % M;
            1: return a & b;
            2: return M - 1 - a;
            3: return a ^ b;
            4: return (a * d) % M;
            5: return a / d;
            6: begin
                sv = sgn(a);
                qv = (sv >= 0) ? sv / d : -((-sv + d - 1) / d);
                return (qv + M) % M;
            end
            default: return 0;
        endcase
    endfunction

    function automatic bit ref_ovf(input int opc, input longint a, input longint b);
        longint s;
        s = sgn(a) + sgn(b);
        return (opc == 0) && (s > 32767 || s < -32768);
    endfunction

    // One clock cycle: drive, check at negedge, advance the model at posedge.
    task automatic do_cycle(input bit rst, input bit iv, input longint a, input longint b,
                            input int opc, input int sh, input bit ldc, input bit ordy);
        bit     exp_rdy, exp_v, acc, ret;
        ent_t   e;
        longint r;
        reset     = rst;
        in_valid  = iv;
        in1       = a[15:0];
        in2       = b[15:0];
        op        = opc[2:0];
        shift     = sh[3:0];
        ld_cc     = ldc;
        out_ready = ordy;
        @(negedge clk);
        exp_rdy = (q.size() < 2) || ordy;
        exp_v   = (q.size() > 0) && (q[0].cyc < edge_cnt);
        check_val("in_ready", in_ready, exp_rdy);
        check_val("out_valid", out_valid, exp_v);
        if (exp_v) begin
            check_val("out", out, q[0].res);
            check_val("ovf", ovf, q[0].ov);
        end
        check_val("nzp", {n, z, p}, cc_m);
        acc = iv && exp_rdy;
        ret = exp_v && ordy;
        @(posedge clk);
        edge_cnt++;
        if (rst) begin
            q.delete();
            cc_m = 3'b010;
        end else begin
            if (ret) begin
                e = q.pop_front();
                if (e.ld) cc_m = (e.res >= 32768) ? 3'b100 : (e.res == 0) ? 3'b010 : 3'b001;
            end
            if (acc) begin
                r = ref_out(opc, a, b, sh);
                q.push_back('{res: r, ov: ref_ovf(opc, a, b), ld: ldc, cyc: edge_cnt});
            end
        end
        #1;
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) do_cycle(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in1 = 16'h0; in2 = 16'h0; op = 3'b000;
        shift = 4'h0; ld_cc = 1'b0; out_ready = 1'b0;
        in_valid32 = 1'b0; in1_32 = 32'h0; in2_32 = 32'h0; op32 = 3'b000;
        shift32 = 5'h0; ld_cc32 = 1'b0; out_ready32 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cc_m = 3'b010;
        check_val("rst_out", out, 16'h0000);
        check_val("rst_ovf", ovf, 1'b0);
        check_val("rst_valid", out_valid, 1'b0);
        check_val("rst_nzp", {n, z, p}, 3'b010);

        // add overflow into negative, with cc load
        do_cycle(1'b0, 1'b1, 'h7FFF, 'h0001, 0, 0, 1'b1, 1'b1);
        do_cycle(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
        check_val("add_out", out, 16'h8000);
        check_val("add_ovf", ovf, 1'b1);
        do_cycle(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
        check_val("add_nzp", {n, z, p}, 3'b100);

        // shifts, back to back
        do_cycle(1'b0, 1'b1, 'h8010, 0, 6, 4, 1'b0, 1'b1);
        do_cycle(1'b0, 1'b1, 'h8010, 0, 5, 4, 1'b0, 1'b1);
        check_val("rshfa", out, 16'hF801);
        check_val("rshfa_ovf", ovf, 1'b0);
        do_cycle(1'b0, 1'b1, 'h0003, 0, 4, 15, 1'b0, 1'b1);
        check_val("rshfl", out, 16'h0801);
        do_cycle(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
        check_val("lshf", out, 16'h8000);
        check_val("lshf_ovf", ovf, 1'b0);
        idle(2);

        // backpressure: two fit, third stalls, then drain in order
        do_cycle(1'b0, 1'b1, 1, 2, 0, 0, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b1, 'h00F0, 'h0F0F, 1, 0, 1'b0, 1'b0);
        check_val("bp_rdy", in_ready, 1'b0);
        check_val("bp_hold1", out, 16'h0003);
        do_cycle(1'b0, 1'b1, 'h1234, 0, 2, 0, 1'b0, 1'b0);
        check_val("bp_hold2", out, 16'h0003);
        check_val("bp_valid", out_valid, 1'b1);
        do_cycle(1'b0, 1'b1, 'h1234, 0, 2, 0, 1'b0, 1'b1);
        idle(3);

        // xor to zero without cc load leaves positive cc
        do_cycle(1'b0, 1'b1, 5, 6, 0, 0, 1'b1, 1'b1);
        do_cycle(1'b0, 1'b1, 'h1234, 'h1234, 3, 0, 1'b0, 1'b1);
        idle(2);
        check_val("xor_nzp", {n, z, p}, 3'b001);

        // reset with both stages full
        do_cycle(1'b0, 1'b1, 'h7000, 'h7000, 0, 0, 1'b1, 1'b0);
        do_cycle(1'b0, 1'b1, 'h0001, 'h0000, 0, 0, 1'b1, 1'b0);
        do_cycle(1'b1, 1'b1, 'h0002, 'h0000, 0, 0, 1'b1, 1'b1);
        check_val("rs_valid", out_valid, 1'b0);
        check_val("rs_rdy", in_ready, 1'b1);
        check_val("rs_nzp", {n, z, p}, 3'b010);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            longint a, b;
            a = $urandom_range(0, 65535);
            b = $urandom_range(0, 65535);
            if ($urandom_range(0, 7) == 0) a = 'h7FFF + $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) == 1) ? 'h8000 : 'h0001;
            do_cycle(1'b0, ($urandom_range(0, 3) != 0), a, b, $urandom_range(0, 7),
                     $urandom_range(0, 15), $urandom_range(0, 1), ($urandom_range(0, 2) != 0));
        end
        idle(3);
        in_valid = 1'b0;

        // 32-bit instance: positive result, then wraparound to zero
        in_valid32 = 1'b1; in1_32 = 32'h1; in2_32 = 32'h1; op32 = 3'b000; ld_cc32 = 1'b1;
        @(posedge clk); #1;
        in1_32 = 32'hFFFF_FFFF; in2_32 = 32'h1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        check_val("w32_first", out32, 32'h2);
        @(posedge clk); #1;
        check_val("w32_valid", out_valid32, 1'b1);
        check_val("w32_out", out32, 32'h0);
        check_val("w32_ovf", ovf32, 1'b0);
        check_val("w32_nzp_p", {n32, z32, p32}, 3'b001);
        @(posedge clk); #1;
        check_val("w32_nzp_z", {n32, z32, p32}, 3'b010);
        check_val("w32_empty", out_valid32, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
